// File: rtl/stopwatch_btn_ctrl.sv
// Stopwatch mode controller: debounced start/function buttons -> counter enable/clear and lap freeze.
// Optional long-press clear when STOPWATCH_LONG_CLR_EN is defined.
module stopwatch_btn_ctrl #(
   parameter int unsigned LONG_CYC = 100_000_000,
   parameter int unsigned HOLD_W   = 27
) (
   input  logic       clk_100,
   input  logic       rst,
   input  logic       pb_s_de,
   input  logic       pb_f_de,
   output logic       cnt_en,
   output logic       cnt_clr,
   output logic       lap_freeze,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      LAP   = 2'b11
   } state_t;

   state_t cur_st, nxt_st;

   logic s_q, s_d, f_q, f_d;
   logic start_ev, short_ev, clear_ev;
   logic long_done;

   always_ff @(posedge clk_100) begin
      if (rst) begin
         s_q <= 1'b0;
         s_d <= 1'b0;
         f_q <= 1'b0;
         f_d <= 1'b0;
      end else begin
         s_q <= pb_s_de;
         s_d <= s_q;
         f_q <= pb_f_de;
         f_d <= f_q;
      end
   end

   assign start_ev = s_q & ~s_d;
   assign short_ev = ~f_q & f_d & ~long_done;

`ifdef STOPWATCH_LONG_CLR_EN
   logic [HOLD_W-1:0] hold_cnt;
   logic              long_ev;

   // Saturating at LONG_CYC keeps long_ev to a single cycle per press.
   always_ff @(posedge clk_100) begin
      if (rst) begin
         hold_cnt  <= '0;
         long_done <= 1'b0;
      end else if (!f_q) begin
         hold_cnt  <= '0;
         long_done <= 1'b0;
      end else begin
         if (hold_cnt != HOLD_W'(LONG_CYC))
            hold_cnt <= hold_cnt + HOLD_W'(1);
         if (long_ev)
            long_done <= 1'b1;
      end
   end

   assign long_ev  = f_q && (hold_cnt == HOLD_W'(LONG_CYC - 1));
   assign clear_ev = long_ev;
`else
   logic unused_cfg;

   assign long_done  = 1'b0;
   assign clear_ev   = short_ev && (cur_st == PAUSE);
   assign unused_cfg = ^{LONG_CYC, HOLD_W};
`endif

   // Priority: clear > start > short.
   always_comb begin
      nxt_st = cur_st;
      if (clear_ev) begin
         nxt_st = IDLE;
      end else if (start_ev) begin
         case (cur_st)
            IDLE, PAUSE: nxt_st = RUN;
            RUN, LAP:    nxt_st = PAUSE;
            default:     nxt_st = cur_st;
         endcase
      end else if (short_ev) begin
         case (cur_st)
            RUN:     nxt_st = LAP;
            LAP:     nxt_st = RUN;
            default: nxt_st = cur_st;
         endcase
      end
   end

   always_ff @(posedge clk_100) begin
      if (rst) begin
         cur_st     <= IDLE;
         cnt_en     <= 1'b0;
         cnt_clr    <= 1'b0;
         lap_freeze <= 1'b0;
      end else begin
         cur_st     <= nxt_st;
         cnt_en     <= (nxt_st == RUN) || (nxt_st == LAP);
         cnt_clr    <= clear_ev;
         lap_freeze <= (nxt_st == LAP);
      end
   end

   assign state = cur_st;

endmodule

// File: tb/tb_stopwatch_btn_ctrl.sv
// Directed bench for stopwatch_btn_ctrl with LONG_CYC=8; long-press sequences follow STOPWATCH_LONG_CLR_EN.
module tb_stopwatch_btn_ctrl;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_LAP   = 2'b11;

   logic       clk_100 = 1'b0;
   logic       rst     = 1'b1;
   logic       pb_s_de = 1'b0;
   logic       pb_f_de = 1'b0;
   logic       cnt_en, cnt_clr, lap_freeze;
   logic [1:0] state;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic       r;
      logic       s;
      logic       f;
      logic [1:0] st;
      logic       en;
      logic       clr;
      logic       frz;
   } vec_t;

   vec_t tbl[$];

   stopwatch_btn_ctrl #(
      .LONG_CYC(8),
      .HOLD_W  (4)
   ) dut (
      .clk_100   (clk_100),
      .rst       (rst),
      .pb_s_de   (pb_s_de),
      .pb_f_de   (pb_f_de),
      .cnt_en    (cnt_en),
      .cnt_clr   (cnt_clr),
      .lap_freeze(lap_freeze),
      .state     (state)
   );

   always #5 clk_100 = ~clk_100;

   task automatic add(input int n, input logic r, s, f,
                      input logic [1:0] st, input logic en, clr, frz);
      vec_t v;
      v.r = r; v.s = s; v.f = f; v.st = st; v.en = en; v.clr = clr; v.frz = frz;
      for (int k = 0; k < n; k++) tbl.push_back(v);
   endtask

   // Inputs are applied on the falling edge; outputs are checked 1 ns after the next rising edge.
   task automatic step(input logic r, s, f, input logic [1:0] st,
                       input logic en, clr, frz, input string name, input int idx);
      logic [4:0] got, exp;
      rst = r; pb_s_de = s; pb_f_de = f;
      @(posedge clk_100);
      #1;
      got = {state, cnt_en, cnt_clr, lap_freeze};
      exp = {st, en, clr, frz};
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s[%0d]: got state/en/clr/frz=%b_%b_%b_%b, expected %b_%b_%b_%b",
                    name, idx, got[4:3], got[2], got[1], got[0], exp[4:3], exp[2], exp[1], exp[0]);
      @(negedge clk_100);
   endtask

   initial begin
      // reset with both buttons held; release with start still held
      add(3, 1, 1, 1, S_IDLE, 0, 0, 0);
      add(1, 0, 1, 0, S_IDLE, 0, 0, 0);
      add(2, 0, 1, 0, S_RUN,  1, 0, 0);
      add(1, 1, 0, 0, S_IDLE, 0, 0, 0);
      add(2, 0, 0, 0, S_IDLE, 0, 0, 0);
      // start/stop: two 5-cycle pulses, rising edges 20 cycles apart
      add(1,  0, 1, 0, S_IDLE,  0, 0, 0);
      add(4,  0, 1, 0, S_RUN,   1, 0, 0);
      add(15, 0, 0, 0, S_RUN,   1, 0, 0);
      add(1,  0, 1, 0, S_RUN,   1, 0, 0);
      add(4,  0, 1, 0, S_PAUSE, 0, 0, 0);
      add(3,  0, 0, 0, S_PAUSE, 0, 0, 0);
      // resume
      add(1, 0, 1, 0, S_PAUSE, 0, 0, 0);
      add(3, 0, 0, 0, S_RUN,   1, 0, 0);
      // lap in, lap out (3-cycle presses)
      add(3, 0, 0, 1, S_RUN, 1, 0, 0);
      add(1, 0, 0, 0, S_RUN, 1, 0, 0);
      add(3, 0, 0, 0, S_LAP, 1, 0, 1);
      add(3, 0, 0, 1, S_LAP, 1, 0, 1);
      add(1, 0, 0, 0, S_LAP, 1, 0, 1);
      add(2, 0, 0, 0, S_RUN, 1, 0, 0);
      // start and short in the same cycle from RUN -> PAUSE
      add(2, 0, 0, 1, S_RUN,   1, 0, 0);
      add(1, 0, 1, 0, S_RUN,   1, 0, 0);
      add(2, 0, 1, 0, S_PAUSE, 0, 0, 0);
      add(1, 0, 0, 0, S_PAUSE, 0, 0, 0);
      // back-to-back: start, short, start on consecutive cycles
      add(1, 0, 1, 0, S_PAUSE, 0, 0, 0);
      add(1, 0, 0, 1, S_RUN,   1, 0, 0);
      add(1, 0, 0, 0, S_RUN,   1, 0, 0);
      add(1, 0, 1, 0, S_LAP,   1, 0, 1);
      add(2, 0, 0, 0, S_PAUSE, 0, 0, 0);

      @(negedge clk_100);
      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].st, tbl[i].en, tbl[i].clr, tbl[i].frz, "tbl", i);

`ifdef STOPWATCH_LONG_CLR_EN
      // short press in PAUSE is ignored
      for (int i = 0; i < 2; i++) step(0, 0, 1, S_PAUSE, 0, 0, 0, "pause_short", i);
      for (int i = 0; i < 3; i++) step(0, 0, 0, S_PAUSE, 0, 0, 0, "pause_short", 2 + i);
      // back to RUN, then long hold: IDLE with one-cycle clear after the 8th high sample
      step(0, 1, 0, S_PAUSE, 0, 0, 0, "to_run", 0);
      step(0, 0, 0, S_RUN,   1, 0, 0, "to_run", 1);
      for (int i = 0; i < 8; i++) step(0, 0, 1, S_RUN, 1, 0, 0, "long_clr", i);
      step(0, 0, 1, S_IDLE, 0, 1, 0, "long_clr", 8);
      step(0, 1, 1, S_IDLE, 0, 0, 0, "long_clr", 9);
      step(0, 0, 1, S_RUN,  1, 0, 0, "long_clr", 10);
      for (int i = 0; i < 9; i++) step(0, 0, 1, S_RUN, 1, 0, 0, "long_hold", i);
      // release after a long press must not act as a short press
      for (int i = 0; i < 3; i++) step(0, 0, 0, S_RUN, 1, 0, 0, "long_release", i);
      // start event and long event in the same cycle: clear wins
      for (int i = 0; i < 7; i++) step(0, 0, 1, S_RUN, 1, 0, 0, "clr_vs_start", i);
      step(0, 1, 1, S_RUN,  1, 0, 0, "clr_vs_start", 7);
      step(0, 0, 1, S_IDLE, 0, 1, 0, "clr_vs_start", 8);
      step(0, 0, 0, S_IDLE, 0, 0, 0, "clr_vs_start", 9);
      step(0, 0, 0, S_IDLE, 0, 0, 0, "clr_vs_start", 10);
`else
      // short press in PAUSE clears back to IDLE with a one-cycle pulse
      for (int i = 0; i < 2; i++) step(0, 0, 1, S_PAUSE, 0, 0, 0, "pause_clr", i);
      step(0, 0, 0, S_PAUSE, 0, 0, 0, "pause_clr", 2);
      step(0, 0, 0, S_IDLE,  0, 1, 0, "pause_clr", 3);
      step(0, 0, 0, S_IDLE,  0, 0, 0, "pause_clr", 4);
      // 20-cycle hold in RUN: nothing until release, then LAP
      step(0, 1, 0, S_IDLE, 0, 0, 0, "to_run", 0);
      step(0, 0, 0, S_RUN,  1, 0, 0, "to_run", 1);
      for (int i = 0; i < 20; i++) step(0, 0, 1, S_RUN, 1, 0, 0, "hold20", i);
      step(0, 0, 0, S_RUN, 1, 0, 0, "hold20", 20);
      step(0, 0, 0, S_LAP, 1, 0, 1, "hold20", 21);
      step(0, 0, 0, S_LAP, 1, 0, 1, "hold20", 22);
      // start and short in the same cycle from PAUSE: clear wins
      step(0, 1, 0, S_LAP,   1, 0, 1, "clr_vs_start", 0);
      step(0, 0, 1, S_PAUSE, 0, 0, 0, "clr_vs_start", 1);
      step(0, 1, 0, S_PAUSE, 0, 0, 0, "clr_vs_start", 2);
      step(0, 0, 0, S_IDLE,  0, 1, 0, "clr_vs_start", 3);
      step(0, 0, 0, S_IDLE,  0, 0, 0, "clr_vs_start", 4);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/stopwatch_btn_ctrl.md
# stopwatch_btn_ctrl

- Mode controller between the two debounced push buttons and the stopwatch counter/display datapath.
- Detects press/release on both buttons and classifies function-button presses as short or long.
- Sequences the counter through IDLE/RUN/PAUSE/LAP, driving its enable and clear, plus the display lap-freeze.
- Replaces per-button one-pulse stages on the stopwatch path: it takes debounced levels directly.

## Interface
- LONG_CYC, 100_000_000, cycles `pb_f_de` must be held to count as a long press (1 s at 100 MHz); legal range 2..2^27-1
- HOLD_W, 27, hold-counter width; must satisfy 2^HOLD_W > LONG_CYC
- clk_100  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- pb_s_de  in  1  debounced start/stop button level, 1 = pressed
- pb_f_de  in  1  debounced function (lap/clear) button level, 1 = pressed
- cnt_en  out  1  stopwatch counter enable
- cnt_clr  out  1  one-cycle counter clear pulse
- lap_freeze  out  1  display holds its last value while 1
- state  out  2  IDLE=00, RUN=01, PAUSE=10, LAP=11

## Operation
- Each button is sampled into an `_q` register, then delayed into a `_d` register.
- Start event: `s_q & ~s_d`. Release of the start button does nothing.
- Hold counter:
  - Increments every cycle `f_q`=1 and saturates at LONG_CYC.
  - Cleared whenever `f_q`=0.
- Long event:
  - One cycle, when `f_q`=1 and the counter equals LONG_CYC-1, i.e. the LONG_CYC-th consecutive high sample.
  - Sets a `long_done` flag, cleared on release.
- Short event: `~f_q & f_d & ~long_done`. A release after a long event produces no short event.
- Transitions (anything not listed leaves the state unchanged):
  - IDLE: start → RUN.
  - RUN: start → PAUSE; short → LAP.
  - LAP: short → RUN; start → PAUSE.
  - PAUSE: start → RUN; clear event → IDLE.
- Priority within a single cycle: clear event > start > short.
- Outputs, all registered and decoded from the next state:
  - `cnt_en`=1 in RUN and LAP.
  - `lap_freeze`=1 only in LAP.
  - `cnt_clr`=1 for exactly the cycle after any transition into IDLE caused by a clear event.
- Reset:
  - All outputs 0, state IDLE.
  - Hold counter, `long_done`, `_q` and `_d` registers all cleared.
  - Reset mid-hold: the press is discarded. A button still held after reset is seen as a new press, because `_d`=0.
- The counter value itself lives in the datapath. This block never counts time beyond the hold counter.

## Timing
- Edge N is the first edge that samples a new button level into `_q`.
- The event is evaluated between N and N+1. State and outputs change at edge N+1: 2-edge latency from an input change to an output.
- Long event fires in the cycle after the edge that captures the LONG_CYC-th high sample. The state change follows at the next edge.
- `cnt_clr` width is exactly 1 cycle, even if the button stays held.
- Back-to-back events on consecutive cycles are each honoured; no input is dropped except by the priority rule above.

## Configuration
- STOPWATCH_LONG_CLR_EN defined:
  - Clear event = long event, accepted in every state.
  - Any state → IDLE, with `cnt_clr`.
  - A short event in PAUSE is ignored.
- Undefined:
  - Long detection and the hold counter are removed.
  - Clear event = short event in PAUSE only.
  - Short events in other states behave as listed above.

## Test plan
- Reset: assert `rst` 3 cycles with both buttons high → outputs 0, state 00. Release `rst` with `pb_s_de` still high → RUN at the 2nd edge, `cnt_en`=1.
- Start/stop: `pb_s_de` pulsed 5 cycles twice, 20 cycles apart → state 00→01→10. `cnt_en` 0→1→0, changing exactly 2 edges after each rising input.
- Lap: in RUN, `pb_f_de` high 3 cycles (LONG_CYC=8) → LAP on release+2 edges, `lap_freeze`=1, `cnt_en`=1. Repeat → RUN, `lap_freeze`=0.
- Long clear (macro on, LONG_CYC=8): in RUN, `pb_f_de` held 20 cycles → IDLE 2 edges after the 8th high sample. `cnt_clr` high exactly 1 cycle; no LAP on release.
- Simultaneous: start event and long event land in the same cycle → IDLE with `cnt_clr` (clear wins). Start and short event in the same cycle from RUN → PAUSE.
- Macro off: in PAUSE, short `pb_f_de` press → IDLE with 1-cycle `cnt_clr`. A 20-cycle hold in RUN → LAP on release only.
